siteswap_pattern_engine: RTL and testbench

//  Beat-paced entry buffer and sequential validator for siteswap patterns up to MAX_LEN throws.

---
 rtl/juggle_pkg.sv | 47 ++++
 rtl/pattern_seg_display.sv | 59 +++++
 rtl/siteswap_pattern_engine.sv | 249 ++++++++++++++++++++++++
 tb/tb_siteswap_pattern_engine.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/juggle_pkg.sv
// Shared types, defaults and seven-segment glyphs for the siteswap pattern engine.
package juggle_pkg;

    localparam int unsigned DEF_MAX_LEN = 7;
    localparam int unsigned DEF_THROW_W = 3;

    typedef logic [DEF_THROW_W-1:0] throw_t;
    typedef throw_t [DEF_MAX_LEN-1:0] pattern_t;

    typedef enum logic [2:0] {
        StEntry,
        StCheck,
        StReduce,
        StMark,
        StDivide,
        StDone
    } state_e;

    // Active-low cathodes, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_R     = 7'b0101111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] hex_glyph(input logic [3:0] v);
        logic [6:0] g;
        unique case (v)
            4'h0: g = 7'b1000000;
            4'h1: g = 7'b1111001;
            4'h2: g = 7'b0100100;
            4'h3: g = 7'b0110000;
            4'h4: g = 7'b0011001;
            4'h5: g = 7'b0010010;
            4'h6: g = 7'b0000010;
            4'h7: g = 7'b1111000;
            4'h8: g = 7'b0000000;
            4'h9: g = 7'b0010000;
            4'ha: g = 7'b0001000;
            4'hb: g = 7'b0000011;
            4'hc: g = 7'b1000110;
            4'hd: g = 7'b0100001;
            4'he: g = 7'b0000110;
            default: g = 7'b0001110;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/pattern_seg_display.sv
// Scanned 8-digit seven-segment driver: shows the entered throws or "Err".
// Instantiated only when SEG_DISPLAY_EN is defined.
module pattern_seg_display
    import juggle_pkg::*;
#(
    parameter int unsigned MAX_LEN      = DEF_MAX_LEN,
    parameter int unsigned THROW_W      = DEF_THROW_W,
    parameter int unsigned LEN_W        = $clog2(MAX_LEN + 1),
    parameter int unsigned DIGIT_PERIOD = 100000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [MAX_LEN*THROW_W-1:0]   digits,
    input  logic [LEN_W-1:0]             len,
    input  logic                         show_err,
    output logic [6:0]                   cat,
    output logic [7:0]                   an
);

    localparam int unsigned CNT_W = $clog2(DIGIT_PERIOD);

    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       pos_q;
    logic [6:0]       cat_d;
    logic [THROW_W-1:0] cur_digit;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            pos_q <= '0;
            cat   <= '1;
            an    <= '1;
        end else begin
            if (cnt_q == CNT_W'(DIGIT_PERIOD - 1)) begin
                cnt_q <= '0;
                pos_q <= pos_q + 3'd1;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            cat <= cat_d;
            an  <= ~(8'b1 << pos_q);
        end
    end

    always_comb begin
        cur_digit = '0;
        for (int k = 0; k < MAX_LEN; k++) begin
            if (pos_q == 3'(k)) cur_digit = digits[k*THROW_W +: THROW_W];
        end
        cat_d = SEG_BLANK;
        if (show_err) begin
            if (pos_q == 3'd0)      cat_d = SEG_E;
            else if (pos_q < 3'd3)  cat_d = SEG_R;
        end else if (32'(pos_q) < 32'(len)) begin
            cat_d = hex_glyph(4'(cur_digit));
        end
    end

endmodule

// File: rtl/siteswap_pattern_engine.sv
// Beat-paced siteswap entry buffer with a sequential landing-slot validator and ball counter.
// Optional scanned display enabled by defining SEG_DISPLAY_EN.
module siteswap_pattern_engine
    import juggle_pkg::*;
#(
    parameter int unsigned MAX_LEN = DEF_MAX_LEN,
    parameter int unsigned THROW_W = DEF_THROW_W,
    localparam int unsigned LEN_W  = $clog2(MAX_LEN + 1),
    localparam int unsigned SUM_W  = $clog2(MAX_LEN * (2**THROW_W - 1) + 1)
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       new_beat,
    input  logic                       clear_in,
    input  logic [THROW_W-1:0]         pattern_in,
    input  logic [LEN_W-1:0]           pattern_length,
    output logic [MAX_LEN*THROW_W-1:0] pattern_out,
    output logic [LEN_W-1:0]           pattern_len_out,
    output logic [THROW_W-1:0]         num_balls_out,
    output logic                       pattern_valid_out,
    output logic                       result_pulse_out,
    output logic                       busy_out,
    output logic [LEN_W-1:0]           entry_index_out,
    output logic [6:0]                 cat_out,
    output logic [7:0]                 an_out
);

    localparam int unsigned ACC_W = LEN_W + 1;

    state_e state_q, state_d;

    logic [MAX_LEN-1:0][THROW_W-1:0] buf_q, buf_d;
    logic [MAX_LEN-1:0]              mask_q, mask_d;
    logic [SUM_W-1:0]                sum_q, sum_d;
    logic [LEN_W-1:0]                idx_q, idx_d;
    logic [LEN_W-1:0]                i_q, i_d;
    logic [LEN_W-1:0]                len_q, len_d;
    logic [ACC_W-1:0]                acc_q, acc_d;
    logic [THROW_W-1:0]              quot_q, quot_d;
    logic                            bad_q, bad_d;

    logic [MAX_LEN*THROW_W-1:0]      pub_pat_q, pub_pat_d;
    logic [LEN_W-1:0]                pub_len_q, pub_len_d;
    logic [THROW_W-1:0]              pub_balls_q, pub_balls_d;
    logic                            valid_q, valid_d;
    logic                            pulse_q, pulse_d;

    logic [THROW_W-1:0]              cur_throw;
    logic                            slot_taken;
    logic [LEN_W-1:0]                len_clamp;
    logic                            start_check;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= StEntry;
            buf_q       <= '0;
            mask_q      <= '0;
            sum_q       <= '0;
            idx_q       <= '0;
            i_q         <= '0;
            len_q       <= '0;
            acc_q       <= '0;
            quot_q      <= '0;
            bad_q       <= 1'b0;
            pub_pat_q   <= '0;
            pub_len_q   <= '0;
            pub_balls_q <= '0;
            valid_q     <= 1'b0;
            pulse_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            buf_q       <= buf_d;
            mask_q      <= mask_d;
            sum_q       <= sum_d;
            idx_q       <= idx_d;
            i_q         <= i_d;
            len_q       <= len_d;
            acc_q       <= acc_d;
            quot_q      <= quot_d;
            bad_q       <= bad_d;
            pub_pat_q   <= pub_pat_d;
            pub_len_q   <= pub_len_d;
            pub_balls_q <= pub_balls_d;
            valid_q     <= valid_d;
            pulse_q     <= pulse_d;
        end
    end

    // Mux the throw under test and its landing-slot occupancy.
    always_comb begin
        cur_throw  = '0;
        slot_taken = 1'b0;
        for (int k = 0; k < MAX_LEN; k++) begin
            if (i_q == LEN_W'(k))   cur_throw  = buf_q[k];
            if (acc_q == ACC_W'(k)) slot_taken = mask_q[k];
        end
        len_clamp = (pattern_length > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : pattern_length;
    end

    always_comb begin
        state_d     = state_q;
        buf_d       = buf_q;
        mask_d      = mask_q;
        sum_d       = sum_q;
        idx_d       = idx_q;
        i_d         = i_q;
        len_d       = len_q;
        acc_d       = acc_q;
        quot_d      = quot_q;
        bad_d       = bad_q;
        pub_pat_d   = pub_pat_q;
        pub_len_d   = pub_len_q;
        pub_balls_d = pub_balls_q;
        valid_d     = valid_q;
        pulse_d     = 1'b0;
        start_check = 1'b0;

        unique case (state_q)
            StEntry: begin
                if (new_beat) begin
                    if (idx_q == '0) begin
                        // A zero length request leaves the entry untouched.
                        if (pattern_length != '0) begin
                            len_d       = len_clamp;
                            buf_d[0]    = pattern_in;
                            idx_d       = LEN_W'(1);
                            start_check = (len_clamp == LEN_W'(1));
                        end
                    end else begin
                        for (int k = 0; k < MAX_LEN; k++) begin
                            if (idx_q == LEN_W'(k)) buf_d[k] = pattern_in;
                        end
                        idx_d       = idx_q + LEN_W'(1);
                        start_check = (idx_q == len_q - LEN_W'(1));
                    end
                end
            end
            StCheck: begin
                acc_d   = ACC_W'(i_q) + ACC_W'(cur_throw);
                state_d = StReduce;
            end
            StReduce: begin
                if (acc_q >= ACC_W'(len_q)) acc_d = acc_q - ACC_W'(len_q);
                else                        state_d = StMark;
            end
            StMark: begin
                bad_d = bad_q | slot_taken;
                for (int k = 0; k < MAX_LEN; k++) begin
                    if (acc_q == ACC_W'(k)) mask_d[k] = 1'b1;
                end
                sum_d = sum_q + SUM_W'(cur_throw);
                if (i_q == len_q - LEN_W'(1)) begin
                    state_d = StDivide;
                end else begin
                    i_d     = i_q + LEN_W'(1);
                    state_d = StCheck;
                end
            end
            StDivide: begin
                if (sum_q >= SUM_W'(len_q)) begin
                    sum_d  = sum_q - SUM_W'(len_q);
                    quot_d = quot_q + THROW_W'(1);
                end else begin
                    state_d = StDone;
                    pulse_d = 1'b1;
                    valid_d = ~bad_q;
                    if (!bad_q) begin
                        pub_pat_d   = buf_q;
                        pub_len_d   = len_q;
                        pub_balls_d = quot_q;
                    end
                end
            end
            StDone: begin
                if (new_beat) begin
                    buf_d   = '0;
                    mask_d  = '0;
                    sum_d   = '0;
                    idx_d   = '0;
                    state_d = StEntry;
                end
            end
            default: state_d = StEntry;
        endcase

        if (start_check) begin
            state_d = StCheck;
            i_d     = '0;
            bad_d   = 1'b0;
            mask_d  = '0;
            sum_d   = '0;
            quot_d  = '0;
        end

        // Abort beats everything, including a verdict that would publish this cycle.
        if (clear_in) begin
            state_d     = StEntry;
            buf_d       = '0;
            mask_d      = '0;
            sum_d       = '0;
            idx_d       = '0;
            pulse_d     = 1'b0;
            valid_d     = valid_q;
            pub_pat_d   = pub_pat_q;
            pub_len_d   = pub_len_q;
            pub_balls_d = pub_balls_q;
        end
    end

    assign pattern_out       = pub_pat_q;
    assign pattern_len_out   = pub_len_q;
    assign num_balls_out     = pub_balls_q;
    assign pattern_valid_out = valid_q;
    assign result_pulse_out  = pulse_q;
    assign entry_index_out   = idx_q;
    assign busy_out          = (state_q == StCheck) || (state_q == StReduce) ||
                               (state_q == StMark)  || (state_q == StDivide);

`ifdef SEG_DISPLAY_EN
    logic [MAX_LEN-1:0][THROW_W-1:0] disp_digits;

    always_comb begin
        disp_digits = buf_q;
        if (state_q == StEntry) begin
            for (int k = 0; k < MAX_LEN; k++) begin
                if (idx_q == LEN_W'(k)) disp_digits[k] = pattern_in;
            end
        end
    end

    pattern_seg_display #(
        .MAX_LEN (MAX_LEN),
        .THROW_W (THROW_W),
        .LEN_W   (LEN_W)
    ) u_display (
        .clk      (clk_in),
        .rst      (rst_in),
        .digits   (disp_digits),
        .len      (len_q),
        .show_err ((state_q == StDone) && bad_q),
        .cat      (cat_out),
        .an       (an_out)
    );
`else
    assign cat_out = '1;
    assign an_out  = '1;
`endif

endmodule

// File: tb/tb_siteswap_pattern_engine.sv
// Self-checking bench: directed siteswap cases plus random patterns against a set-based model.
module tb_siteswap_pattern_engine;

    localparam int MAXL = 7;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        new_beat = 1'b0;
    logic        clear_in = 1'b0;
    logic [2:0]  pattern_in = '0;
    logic [2:0]  pattern_length = '0;
    logic [20:0] pattern_out;
    logic [2:0]  pattern_len_out;
    logic [2:0]  num_balls_out;
    logic        pattern_valid_out;
    logic        result_pulse_out;
    logic        busy_out;
    logic [2:0]  entry_index_out;
    logic [6:0]  cat_out;
    logic [7:0]  an_out;

    int n_checks = 0;
    int n_fail   = 0;
    bit in_done  = 0;

    // Model of the last published valid pattern.
    logic [20:0] mdl_pat   = '0;
    int          mdl_len   = 0;
    int          mdl_balls = 0;
    bit          mdl_valid = 0;

    siteswap_pattern_engine dut (
        .clk_in            (clk),
        .rst_in            (rst),
        .new_beat          (new_beat),
        .clear_in          (clear_in),
        .pattern_in        (pattern_in),
        .pattern_length    (pattern_length),
        .pattern_out       (pattern_out),
        .pattern_len_out   (pattern_len_out),
        .num_balls_out     (num_balls_out),
        .pattern_valid_out (pattern_valid_out),
        .result_pulse_out  (result_pulse_out),
        .busy_out          (busy_out),
        .entry_index_out   (entry_index_out),
        .cat_out           (cat_out),
        .an_out            (an_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the following negedge with new_beat low.
    task automatic do_beat(input logic [2:0] v);
        new_beat   = 1'b1;
        pattern_in = v;
        @(negedge clk);
        new_beat   = 1'b0;
    endtask

    task automatic check_published(input string tag);
        check({tag, "_valid"}, 32'(pattern_valid_out), 32'(mdl_valid));
        check({tag, "_pat"},   32'(pattern_out),       32'(mdl_pat));
        check({tag, "_len"},   32'(pattern_len_out),   32'(mdl_len));
        check({tag, "_balls"}, 32'(num_balls_out),     32'(mdl_balls));
    endtask

    task automatic run_pattern(input string tag, input int req, input int unsigned p[MAXL],
                               input bit poke);
        int len;
        int cyc;
        int sum;
        bit ok;
        bit seen[MAXL];
        logic [20:0] flat;
        if (in_done) do_beat(3'd0);
        len = (req > MAXL) ? MAXL : req;
        pattern_length = 3'(req);
        for (int i = 0; i < len; i++) do_beat(3'(p[i]));
        if (poke) begin
            check({tag, "_busy"}, 32'(busy_out), 32'd1);
            do_beat(3'($urandom_range(7)));
            check({tag, "_busy_idx"}, 32'(entry_index_out), 32'(len));
        end
        ok   = 1;
        sum  = 0;
        flat = '0;
        for (int i = 0; i < MAXL; i++) seen[i] = 0;
        for (int i = 0; i < len; i++) begin
            int slot;
            slot = (i + int'(p[i])) % len;
            if (seen[slot]) ok = 0;
            seen[slot] = 1;
            sum += int'(p[i]);
            flat[i*3 +: 3] = 3'(p[i]);
        end
        mdl_valid = ok;
        if (ok) begin
            mdl_pat   = flat;
            mdl_len   = len;
            mdl_balls = sum / len;
        end
        cyc = 0;
        while (!result_pulse_out && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_pulse"}, 32'(result_pulse_out), 32'd1);
        check_published(tag);
        @(negedge clk);
        check({tag, "_pulse_width"}, 32'(result_pulse_out), 32'd0);
        in_done = 1;
    endtask

    initial begin
        int unsigned p[MAXL];
        int unsigned perm[MAXL];
        int pulses;

        repeat (3) @(negedge clk);
        check("rst_pulse", 32'(result_pulse_out), 32'd0);
        check("rst_valid", 32'(pattern_valid_out), 32'd0);
        check("rst_pat",   32'(pattern_out), 32'd0);
        check("rst_len",   32'(pattern_len_out), 32'd0);
        check("rst_balls", 32'(num_balls_out), 32'd0);
        check("rst_busy",  32'(busy_out), 32'd0);
        check("rst_idx",   32'(entry_index_out), 32'd0);
        check("rst_cat",   32'(cat_out), 32'h7f);
        check("rst_an",    32'(an_out), 32'hff);
        rst = 1'b0;
        @(negedge clk);

        p = '{3, 0, 0, 0, 0, 0, 0};
        run_pattern("len1_3", 1, p, 0);
        p = '{5, 3, 1, 0, 0, 0, 0};
        run_pattern("p531", 3, p, 0);
        p = '{5, 4, 3, 0, 0, 0, 0};
        run_pattern("p543_bad", 3, p, 0);
        p = '{4, 4, 1, 0, 0, 0, 0};
        run_pattern("p441", 3, p, 1);
        p = '{0, 0, 0, 0, 0, 0, 0};
        run_pattern("len1_0", 1, p, 0);
        p = '{7, 7, 7, 7, 7, 7, 7};
        run_pattern("seven7", 7, p, 1);

        // A zero length request ignores the first beat.
        do_beat(3'd0);
        in_done = 0;
        pattern_length = 3'd0;
        do_beat(3'd5);
        check("len0_idx",  32'(entry_index_out), 32'd0);
        check("len0_busy", 32'(busy_out), 32'd0);

        // Clear while reducing, with a simultaneous beat.
        pattern_length = 3'd1;
        do_beat(3'd7);
        @(negedge clk);
        check("clr_busy_before", 32'(busy_out), 32'd1);
        clear_in   = 1'b1;
        new_beat   = 1'b1;
        pattern_in = 3'd5;
        @(negedge clk);
        clear_in = 1'b0;
        new_beat = 1'b0;
        check("clr_idx",  32'(entry_index_out), 32'd0);
        check("clr_busy", 32'(busy_out), 32'd0);
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            if (result_pulse_out) pulses++;
            @(negedge clk);
        end
        check("clr_no_pulse", 32'(pulses), 32'd0);
        check("clr_held_pat",   32'(pattern_out), 32'(mdl_pat));
        check("clr_held_balls", 32'(num_balls_out), 32'(mdl_balls));
        check("clr_idx_after",  32'(entry_index_out), 32'd0);

        for (int t = 0; t < 40; t++) begin
            int len;
            len = int'($urandom_range(MAXL, 1));
            for (int i = 0; i < MAXL; i++) begin
                p[i] = 0;
                perm[i] = i;
            end
            if ($urandom_range(1) == 1) begin
                for (int i = len - 1; i > 0; i--) begin
                    int j;
                    int unsigned tmp;
                    j = int'($urandom_range(i));
                    tmp = perm[i];
                    perm[i] = perm[j];
                    perm[j] = tmp;
                end
                for (int i = 0; i < len; i++) begin
                    p[i] = (perm[i] + len - i) % len;
                    while (p[i] + len <= 7 && $urandom_range(1) == 1) p[i] += len;
                end
            end else begin
                for (int i = 0; i < len; i++) p[i] = $urandom_range(7);
            end
            run_pattern("rand", len, p, $urandom_range(3) == 0);
        end

        // Reset in the middle of entry.
        do_beat(3'd0);
        pattern_length = 3'd3;
        do_beat(3'd2);
        do_beat(3'd6);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        in_done = 0;
        mdl_pat = '0; mdl_len = 0; mdl_balls = 0; mdl_valid = 0;
        check("mid_rst_idx",  32'(entry_index_out), 32'd0);
        check("mid_rst_busy", 32'(busy_out), 32'd0);
        check_published("mid_rst");
        p = '{3, 0, 0, 0, 0, 0, 0};
        run_pattern("post_rst", 1, p, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
